// File: rtl/reg_writeback_pkg.sv
// Shared configuration for the register-file writeback path: default widths, the
// zero-register address, the write-strobe level and the queued result record.
package reg_writeback_pkg;

    localparam int unsigned RegAddrLen = 5;
    localparam int unsigned RegLen = 32;

    localparam logic [RegAddrLen-1:0] RegAddrZero = '0;
    localparam logic WriteEnable = 1'b1;

    typedef struct packed {
        logic [RegAddrLen-1:0] rd;
        logic [RegLen-1:0]     data;
    } wb_result_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO for queued writeback results (synchronous active-low reset).
// full/empty decode only the registered occupancy, so they never depend on this cycle's pop.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    cnt_q;
    logic             do_push, do_pop;

    assign full     = (cnt_q == (PtrW + 1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign pop_data = mem[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write port producer: arbitrates ALU/load results into a FIFO, drains one per
// cycle, and tracks outstanding writes per register. REG_WRITEBACK_BYPASS_EN skips an empty FIFO.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = RegAddrLen,
    parameter int unsigned DATA_W = RegLen,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_rd,
    output logic                   issue_ready,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_rd,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   ld_ready,
    input  logic [ADDR_W-1:0]      query_addr1,
    input  logic [ADDR_W-1:0]      query_addr2,
    output logic                   hazard1,
    output logic                   hazard2,
    output logic                   write_enable,
    output logic [ADDR_W-1:0]      write_addr,
    output logic [DATA_W-1:0]      write_data,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned EntryW  = ADDR_W + DATA_W;
    localparam int unsigned NumRegs = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  CntMax   = '1;
    localparam logic [ADDR_W-1:0] AddrZero = ADDR_W'(RegAddrZero);

    logic              fifo_full, fifo_empty;
    logic              push, fifo_push, pop, bypass;
    logic [ADDR_W-1:0] push_rd, head_rd, out_rd;
    logic [DATA_W-1:0] push_data, head_data, out_data;
    logic [EntryW-1:0] head_entry;
    logic              out_valid, wr_fire;

    // Load wins arbitration; readies look only at the registered full flag.
    assign ld_ready  = !fifo_full;
    assign alu_ready = !fifo_full && !ld_valid;
    assign push      = (ld_valid && ld_ready) || (alu_valid && alu_ready);
    assign push_rd   = ld_valid ? ld_rd : alu_rd;
    assign push_data = ld_valid ? ld_data : alu_data;
    assign pop       = !fifo_empty;

`ifdef REG_WRITEBACK_BYPASS_EN
    assign bypass = push && fifo_empty;
`else
    assign bypass = 1'b0;
`endif
    assign fifo_push = push && !bypass;

    wb_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(EntryW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data({push_rd, push_data}),
        .pop      (pop),
        .pop_data (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign {head_rd, head_data} = head_entry;

    always_comb begin
        out_valid = 1'b0;
        out_rd    = head_rd;
        out_data  = head_data;
        if (bypass) begin
            out_valid = 1'b1;
            out_rd    = push_rd;
            out_data  = push_data;
        end else if (pop) begin
            out_valid = 1'b1;
        end
    end

    // x0 results are consumed silently: no strobe, address/data keep their last value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_enable <= !WriteEnable;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= !WriteEnable;
            if (out_valid && (out_rd != AddrZero)) begin
                write_enable <= WriteEnable;
                write_addr   <= out_rd;
                write_data   <= out_data;
            end
        end
    end

    assign wr_fire = (write_enable == WriteEnable);

    logic [CNT_W-1:0] cnt_q [NumRegs];
    logic [CNT_W-1:0] cnt_d [NumRegs];
    logic             issue_fire, retire;

    assign issue_ready = (cnt_q[issue_rd] != CntMax) || (issue_rd == AddrZero);
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != AddrZero);
    assign retire      = wr_fire && (write_addr != AddrZero);

    always_comb begin
        for (int r = 0; r < NumRegs; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_fire && (issue_rd == ADDR_W'(r))
                    && !(retire && (write_addr == ADDR_W'(r)))) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (retire && (write_addr == ADDR_W'(r))
                    && !(issue_fire && (issue_rd == ADDR_W'(r)))
                    && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NumRegs; r++) cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A final write landing this cycle is forwarded by the register file, so it is no hazard.
    assign hazard1 = (query_addr1 != AddrZero) && (cnt_q[query_addr1] != '0)
                     && !(wr_fire && (write_addr == query_addr1)
                          && (cnt_q[query_addr1] == CNT_W'(1)));
    assign hazard2 = (query_addr2 != AddrZero) && (cnt_q[query_addr2] != '0)
                     && !(wr_fire && (write_addr == query_addr2)
                          && (cnt_q[query_addr2] == CNT_W'(1)));

    retire_has_outstanding: assert property (
        @(posedge clk) disable iff (!rst) retire |-> (cnt_q[write_addr] != '0)
    );

endmodule
